// File: rtl/bcd_down_counter3.sv
// 3-digit cascaded BCD/hex down-counter with preset load, one-cycle expiry pulse and busy flag.
// Optional build macro AUTO_RELOAD_EN: reload the preset after expiry instead of halting.
module bcd_down_counter3 #(
    parameter int DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    output logic [3:0] qout1,
    output logic [3:0] qout2,
    output logic [3:0] qout3,
    output logic       bout,
    output logic       busy
);

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t     state_q;
    logic [3:0] count_q   [3];
    logic [3:0] preset_q  [3];
    logic [3:0] din_w     [3];
    logic [3:0] din_clamp [3];
    logic [3:0] dec_d     [3];
    logic [2:0] borrow;
    logic       bout_q;
    logic       busy_q;
    logic       is_one;
    logic       is_zero;
    logic       load_zero;

    assign din_w[0] = din1;
    assign din_w[1] = din2;
    assign din_w[2] = din3;
    assign borrow[0] = 1'b1;

    // Digit 0 always borrows; each higher digit borrows only when every lower digit wraps.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign din_clamp[gi] = (din_w[gi] > DMAX) ? DMAX : din_w[gi];
            assign dec_d[gi]     = !borrow[gi]          ? count_q[gi] :
                                   (count_q[gi] == 4'd0) ? DMAX : count_q[gi] - 4'd1;
            if (gi < 2) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (count_q[gi] == 4'd0);
            end
        end
    endgenerate

    assign is_zero   = (count_q[0] == 4'd0) && (count_q[1] == 4'd0) && (count_q[2] == 4'd0);
    assign is_one    = (count_q[0] == 4'd1) && (count_q[1] == 4'd0) && (count_q[2] == 4'd0);
    assign load_zero = (din_clamp[0] == 4'd0) && (din_clamp[1] == 4'd0) && (din_clamp[2] == 4'd0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= IDLE;
            count_q  <= '{default: 4'd0};
            preset_q <= '{default: 4'd0};
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (load) begin
            count_q  <= din_clamp;
            preset_q <= din_clamp;
            bout_q   <= 1'b0;
            state_q  <= load_zero ? EXPIRED : RUN;
            busy_q   <= !load_zero;
        end else begin
            bout_q <= 1'b0;
            if (state_q == RUN && enable) begin
`ifdef AUTO_RELOAD_EN
                // The cycle after expiry restores the preset, so the period is preset+1.
                if (is_zero) begin
                    count_q <= preset_q;
                end else begin
                    count_q <= dec_d;
                    if (is_one) begin
                        bout_q <= 1'b1;
                    end
                end
`else
                count_q <= dec_d;
                if (is_one) begin
                    bout_q  <= 1'b1;
                    state_q <= EXPIRED;
                    busy_q  <= 1'b0;
                end
`endif
            end
        end
    end

    assign qout1 = count_q[0];
    assign qout2 = count_q[1];
    assign qout3 = count_q[2];
    assign bout  = bout_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bcd_down_counter3.sv
// Scoreboard bench for bcd_down_counter3: a BCD instance and a hex (DIGIT_MAX=15) instance.
module tb_bcd_down_counter3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       m_reset = 1'b1, m_clear = 1'b0, m_load = 1'b0, m_enable = 1'b0;
    logic [3:0] m_din1 = 4'd0, m_din2 = 4'd0, m_din3 = 4'd0;
    logic [3:0] m_q1, m_q2, m_q3;
    logic       m_bout, m_busy;

    logic       h_reset = 1'b1, h_clear = 1'b0, h_load = 1'b0, h_enable = 1'b0;
    logic [3:0] h_din1 = 4'd0, h_din2 = 4'd0, h_din3 = 4'd0;
    logic [3:0] h_q1, h_q2, h_q3;
    logic       h_bout, h_busy;

    bcd_down_counter3 #(.DIGIT_MAX(9)) u_dut (
        .clk(clk), .reset(m_reset), .clear(m_clear), .load(m_load), .enable(m_enable),
        .din1(m_din1), .din2(m_din2), .din3(m_din3),
        .qout1(m_q1), .qout2(m_q2), .qout3(m_q3), .bout(m_bout), .busy(m_busy)
    );

    bcd_down_counter3 #(.DIGIT_MAX(15)) u_hex (
        .clk(clk), .reset(h_reset), .clear(h_clear), .load(h_load), .enable(h_enable),
        .din1(h_din1), .din2(h_din2), .din3(h_din3),
        .qout1(h_q1), .qout2(h_q2), .qout3(h_q3), .bout(h_bout), .busy(h_busy)
    );

    typedef struct {
        bit          hex;
        bit          chk;
        logic [11:0] q;
        logic        b;
        logic        bz;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Monitor: one scoreboard entry per clock edge, compared just after the edge.
    exp_t        mon_e;
    logic [11:0] got_q;
    logic        got_b, got_bz;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            got_q  = mon_e.hex ? {h_q3, h_q2, h_q1} : {m_q3, m_q2, m_q1};
            got_b  = mon_e.hex ? h_bout : m_bout;
            got_bz = mon_e.hex ? h_busy : m_busy;
            if (mon_e.chk) begin
                total_cnt++;
                if (got_q === mon_e.q && got_b === mon_e.b && got_bz === mon_e.bz) begin
                    pass_cnt++;
                    $display("ok   %s: q=%03h bout=%b busy=%b", mon_e.name, got_q, got_b, got_bz);
                end else begin
                    $display("FAIL %s: got q=%03h bout=%b busy=%b, expected q=%03h bout=%b busy=%b",
                             mon_e.name, got_q, got_b, got_bz, mon_e.q, mon_e.b, mon_e.bz);
                end
            end
        end
    end

    task automatic push(input bit hex, input bit chk, input logic [11:0] eq,
                        input logic eb, input logic ebz, input string nm);
        exp_t e;
        e.hex = hex; e.chk = chk; e.q = eq; e.b = eb; e.bz = ebz; e.name = nm;
        sb_q.push_back(e);
    endtask

    // One clock on the BCD instance; din packs {digit3, digit2, digit1}.
    task automatic cyc(input bit rst, input bit clr, input bit ld, input bit en,
                       input logic [11:0] din, input bit chk, input logic [11:0] eq,
                       input logic eb, input logic ebz, input string nm);
        @(negedge clk);
        m_reset = rst; m_clear = clr; m_load = ld; m_enable = en;
        {m_din3, m_din2, m_din1} = din;
        push(1'b0, chk, eq, eb, ebz, nm);
    endtask

    task automatic hcyc(input bit rst, input bit clr, input bit ld, input bit en,
                        input logic [11:0] din, input logic [11:0] eq,
                        input logic eb, input logic ebz, input string nm);
        @(negedge clk);
        h_reset = rst; h_clear = clr; h_load = ld; h_enable = en;
        {h_din3, h_din2, h_din1} = din;
        push(1'b1, 1'b1, eq, eb, ebz, nm);
    endtask

    initial begin
        int v;
        // 1: reset with random inputs, then enable alone in IDLE
        for (int i = 0; i < 2; i++)
            cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                12'($urandom), 1, 12'h000, 0, 0, "reset");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0, "idle_enable");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0, "idle_enable");

        // 2: load 021 and count down to 000
        cyc(0, 0, 1, 0, 12'h021, 1, 12'h021, 0, 1, "load_021");
        for (int k = 1; k <= 21; k++) begin
            v = 21 - k;
`ifdef AUTO_RELOAD_EN
            cyc(0, 0, 0, 1, 12'h000, 1, {4'd0, 4'(v / 10), 4'(v % 10)}, v == 0, 1, "countdown");
`else
            cyc(0, 0, 0, 1, 12'h000, 1, {4'd0, 4'(v / 10), 4'(v % 10)}, v == 0, v != 0, "countdown");
`endif
        end
`ifdef AUTO_RELOAD_EN
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h021, 0, 1, "reload_021");
        cyc(0, 1, 0, 1, 12'h000, 1, 12'h000, 0, 0, "clear_reload");
`else
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0, "expired_hold");
`endif

        // 3: borrow chain and zero load
        cyc(0, 0, 1, 0, 12'h100, 1, 12'h100, 0, 1, "load_100");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h099, 0, 1, "borrow_099");
        cyc(0, 0, 1, 1, 12'h000, 1, 12'h000, 0, 0, "load_000");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0, "zero_expired");

        // 4: pause, load-over-enable priority, clear mid-count
        cyc(0, 0, 1, 0, 12'h005, 1, 12'h005, 0, 1, "load_005");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h004, 0, 1, "dec_004");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h003, 0, 1, "dec_003");
        for (int k = 0; k < 5; k++)
            cyc(0, 0, 0, 0, 12'h000, 1, 12'h003, 0, 1, "pause");
        cyc(0, 0, 1, 1, 12'h007, 1, 12'h007, 0, 1, "load_wins");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h006, 0, 1, "dec_006");
        cyc(0, 1, 1, 1, 12'h003, 1, 12'h000, 0, 0, "clear_wins");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0, "clear_idle");

        // 5: clamp on the BCD instance
        cyc(0, 0, 1, 0, 12'hFFF, 1, 12'h999, 0, 1, "clamp_999");
        cyc(0, 0, 0, 1, 12'h000, 1, 12'h998, 0, 1, "dec_998");
        cyc(0, 0, 1, 0, 12'h0A3, 1, 12'h093, 0, 1, "clamp_093");

`ifdef AUTO_RELOAD_EN
        // 6: periodic reload of preset 002
        cyc(0, 0, 1, 0, 12'h002, 1, 12'h002, 0, 1, "load_002");
        for (int k = 0; k < 9; k++) begin
            v = 1 - (k % 3);
            if (v < 0) v = 2;
            cyc(0, 0, 0, 1, 12'h000, 1, 12'(v), v == 0, 1, "auto_reload");
        end
`endif
        cyc(0, 1, 0, 0, 12'h000, 1, 12'h000, 0, 0, "final_clear");

        // Hex-digit instance
        hcyc(1, 0, 0, 0, 12'h000, 12'h000, 0, 0, "hex_reset");
        hcyc(0, 0, 1, 0, 12'h100, 12'h100, 0, 1, "hex_load_100");
        hcyc(0, 0, 0, 1, 12'h000, 12'h0FF, 0, 1, "hex_borrow_0FF");
        hcyc(0, 0, 0, 1, 12'h000, 12'h0FE, 0, 1, "hex_dec_0FE");
        hcyc(0, 0, 1, 0, 12'hFFF, 12'hFFF, 0, 1, "hex_noclamp");
        hcyc(0, 0, 0, 1, 12'h000, 12'hFFE, 0, 1, "hex_dec_FFE");
        hcyc(0, 0, 1, 0, 12'h001, 12'h001, 0, 1, "hex_load_001");
`ifdef AUTO_RELOAD_EN
        hcyc(0, 0, 0, 1, 12'h000, 12'h000, 1, 1, "hex_terminal");
`else
        hcyc(0, 0, 0, 1, 12'h000, 12'h000, 1, 0, "hex_terminal");
`endif
        hcyc(0, 0, 0, 0, 12'h000, 12'h000, 0, 1'(`ifdef AUTO_RELOAD_EN 1 `else 0 `endif), "hex_pulse_end");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
